prog_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of the instruction-fetch stage. It takes raw bytes from the UART receiver, parses a length-prefixed program image, and drives the fetch stage's loader port (`input_start`, `input_data`, `input_valid`, `input_end`) so instruction memory is filled before execution resumes. It also checks that the image fits the instruction memory and reports completion and errors to the top level.

---
 rtl/prog_loader.sv | 186 ++++++++++++++++++
 tb/tb_prog_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Length-prefixed program loader: parses a UART byte stream and drives the fetch loader port.
// Optional trailing XOR checksum is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int unsigned INST_MEM_WIDTH = 2
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] input_data,
   output logic       input_valid,
   output logic       input_start,
   output logic       input_end,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned CntW = INST_MEM_WIDTH + 3;
   localparam logic [31:0] Capacity = 32'd1 << INST_MEM_WIDTH;
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   typedef enum logic [2:0] {
      StIdle,
      StLen,
      StStart,
      StData,
`ifdef PROG_LOADER_CHECKSUM_EN
      StChk,
`endif
      StEnd,
      StDone,
      StErr
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       len_q, len_d;
   logic [1:0]        len_cnt_q, len_cnt_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              start_q, start_d;
   logic              end_q, end_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              accept;
   logic [31:0]       len_full;
   logic [CntW-1:0]   total;
   logic [CntW-1:0]   cnt_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        xor_q, xor_d;
   logic              chk_bad_q, chk_bad_d;
`endif

   assign len_full = {len_q[23:0], rx_data};
   // Only reached once N has passed the capacity check, so N fits in INST_MEM_WIDTH+1 bits.
   assign total    = {len_q[INST_MEM_WIDTH:0], 2'b00};
   assign cnt_inc  = cnt_q + CntOne;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      len_cnt_d = len_cnt_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      accept    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_d     = xor_q;
      chk_bad_d = chk_bad_q;
`endif

      case (state_q)
         StIdle: begin
            if (rx_valid) begin
               len_d     = {24'd0, rx_data};
               len_cnt_d = 2'd1;
               state_d   = StLen;
            end
         end
         StLen: begin
            if (rx_valid) begin
               len_d     = len_full;
               len_cnt_d = len_cnt_q + 2'd1;
               if (len_cnt_q == 2'd3) begin
                  state_d = (len_full > Capacity) ? StErr : StStart;
               end
            end
         end
         StStart: begin
            accept  = rx_valid && (len_q != 32'd0);
            state_d = (len_q == 32'd0) ? StEnd : StData;
         end
         StData: begin
`ifdef PROG_LOADER_CHECKSUM_EN
            accept = rx_valid;
            if (accept && (cnt_inc == total)) begin
               state_d = StChk;
            end
`else
            // One idle cycle after the last byte so input_end trails the last input_valid.
            if (cnt_q == total) begin
               state_d = StEnd;
            end else begin
               accept = rx_valid;
            end
`endif
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         StChk: begin
            if (rx_valid) begin
               chk_bad_d = (rx_data != xor_q);
               state_d   = StEnd;
            end
         end
         StEnd: state_d = chk_bad_q ? StErr : StDone;
`else
         StEnd: state_d = StDone;
`endif
         StDone: state_d = StDone;
         StErr:  state_d = StErr;
         default: state_d = StIdle;
      endcase

      if (accept) begin
         cnt_d  = cnt_inc;
         data_d = rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
         xor_d  = xor_q ^ rx_data;
`endif
      end

      // Outputs are registered and line up with the state being entered.
      valid_d = accept;
      start_d = (state_d == StStart);
      end_d   = (state_d == StEnd);
      done_d  = (state_d == StDone);
      error_d = (state_d == StErr);
      busy_d  = !(state_d inside {StIdle, StDone, StErr});
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q   <= StIdle;
         len_q     <= '0;
         len_cnt_q <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         xor_q     <= '0;
         chk_bad_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         len_cnt_q <= len_cnt_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         start_q   <= start_d;
         end_q     <= end_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         xor_q     <= xor_d;
         chk_bad_q <= chk_bad_d;
`endif
      end
   end

   assign input_data  = data_q;
   assign input_valid = valid_q;
   assign input_start = start_q;
   assign input_end   = end_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random images and gaps checked against an event-level model.
// Checksum scenarios are included when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

   localparam int unsigned W = 2;
   localparam longint unsigned Cap = 64'd1 << W;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'd0;
   logic       rx_valid = 1'b0;
   logic [7:0] input_data;
   logic       input_valid, input_start, input_end, busy, done, error;

   prog_loader #(.INST_MEM_WIDTH(W)) dut (
      .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .input_data(input_data), .input_valid(input_valid), .input_start(input_start),
      .input_end(input_end), .busy(busy), .done(done), .error(error)
   );

   always #5 CLK = ~CLK;

   int ecnt = 0;
   always @(posedge CLK) ecnt <= ecnt + 1;

   int n_chk = 0;
   int n_pass = 0;

   // Observed loader-port events, tagged with the cycle they were seen in.
   logic       mon_en = 1'b0;
   int         q_vc[$];
   logic [7:0] q_vd[$];
   int         q_s[$];
   int         q_e[$];
   int         overlap = 0;
   int         hold_bad = 0;
   logic [7:0] last_d = 8'd0;

   always @(negedge CLK) begin
      if (mon_en) begin
         if (input_valid) begin
            q_vc.push_back(ecnt);
            q_vd.push_back(input_data);
            last_d = input_data;
         end else if (input_data !== last_d) begin
            hold_bad++;
         end
         if (input_start) q_s.push_back(ecnt);
         if (input_end) q_e.push_back(ecnt);
         if (input_start && input_valid) overlap++;
      end
   end

   logic [7:0] img[$];
   int         rx_cyc[$];
   int         chk_flip = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic put(input bit v, input logic [7:0] b);
      rx_valid = v;
      rx_data  = v ? b : 8'($urandom);
      if (v) rx_cyc.push_back(ecnt);
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic clear_mon();
      q_vc.delete(); q_vd.delete(); q_s.delete(); q_e.delete(); rx_cyc.delete();
      overlap = 0; hold_bad = 0; last_d = 8'd0;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      chk({tag, "_rst"}, {input_data, input_valid, input_start, input_end, busy, done, error},
          0);
      reset = 1'b0;
      clear_mon();
   endtask

   // Length bytes, then 4*N random data bytes (or a few stray bytes if oversize).
   task automatic mk(input logic [31:0] n);
      logic [7:0] x;
      int nd;
      img.delete();
      img.push_back(n[31:24]); img.push_back(n[23:16]);
      img.push_back(n[15:8]);  img.push_back(n[7:0]);
      nd = (longint'(n) <= Cap) ? 4 * int'(n) : 6;
      x = 8'd0;
      for (int i = 0; i < nd; i++) begin
         img.push_back(8'($urandom));
         x ^= img[img.size() - 1];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (longint'(n) <= Cap && n != 0) img.push_back(x ^ 8'(chk_flip));
`endif
   endtask

   task automatic run(input int gap, input string tag);
      longint unsigned n;
      bit   ok_len;
      int   exp_nv, exp_ne, nv;
      longint end_cyc, obs;
      bit   exp_done;
      logic [7:0] x;
      do_reset(tag);
      mon_en = 1'b1;
      foreach (img[i]) begin
         repeat ((gap < 0) ? $urandom_range(3, 0) : gap) put(1'b0, 8'd0);
         put(1'b1, img[i]);
         if (i == 0) chk({tag, "_busy_up"}, busy, 1);
      end
      repeat (2) begin
         repeat ($urandom_range(2, 0)) put(1'b0, 8'd0);
         put(1'b1, 8'($urandom));
      end
      repeat (6) put(1'b0, 8'd0);
      mon_en = 1'b0;

      n = {32'd0, img[0], img[1], img[2], img[3]};
      ok_len = (n <= Cap);
      nv = ok_len ? 4 * int'(n) : 0;
      exp_nv = nv;
      exp_ne = ok_len ? 1 : 0;
      exp_done = ok_len;
      end_cyc = (n == 0) ? rx_cyc[3] + 2 : rx_cyc[3 + nv] + 2;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (ok_len && n != 0) begin
         x = 8'd0;
         for (int i = 0; i < nv; i++) x ^= img[4 + i];
         exp_done = (img[4 + nv] == x);
         end_cyc = rx_cyc[4 + nv] + 1;
      end
`endif
      chk({tag, "_nstart"}, q_s.size(), exp_ne);
      chk({tag, "_nvalid"}, q_vc.size(), exp_nv);
      chk({tag, "_nend"}, q_e.size(), exp_ne);
      if (ok_len) begin
         chk({tag, "_start_cyc"}, (q_s.size() > 0) ? q_s[0] : -1, rx_cyc[3] + 1);
         chk({tag, "_end_cyc"}, (q_e.size() > 0) ? q_e[0] : -1, end_cyc);
      end
      for (int i = 0; i < exp_nv; i++) begin
         obs = (i < q_vc.size()) ? ((longint'(q_vc[i]) << 8) | longint'(q_vd[i])) : -1;
         chk($sformatf("%s_vld%0d", tag, i), obs,
             (longint'(rx_cyc[4 + i] + 1) << 8) | longint'(img[4 + i]));
      end
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_error"}, error, !exp_done);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_overlap"}, overlap, 0);
      chk({tag, "_hold"}, hold_bad, 0);
   endtask

   initial begin
      int r;
      logic [31:0] n;

      mk(32'd2);           run(2, "n2_slow");
      mk(32'd2);           run(0, "n2_b2b");
      mk(32'd0);           run(-1, "n0");
      mk(32'd5);           run(-1, "n5_ovf");
      mk(32'h0000_0104);   run(0, "ovf_trunc");
      mk(32'h8000_0001);   run(-1, "ovf_msb");
      mk(32'd4);           run(0, "n4_full");
      for (int k = 0; k < 8; k++) begin
         r = $urandom_range(9, 0);
         n = (r < 5) ? 32'(r) : ((r < 8) ? 32'(Cap + 1 + $urandom_range(10, 0)) : $urandom);
         mk(n);
         run(-1, $sformatf("rnd%0d", k));
      end

      // Reset after the third data byte of an N=1 image.
      do_reset("mid");
      mon_en = 1'b1;
      mk(32'd1);
      for (int i = 0; i < 7; i++) put(1'b1, img[i]);
      reset = 1'b1;
      @(posedge CLK);
      #1;
      chk("mid_rst_outs", {input_data, input_valid, input_start, input_end, busy, done, error}, 0);
      reset = 1'b0;
      repeat (4) put(1'b0, 8'd0);
      mon_en = 1'b0;
      chk("mid_no_end", q_e.size(), 0);
      mk(32'd1);           run(-1, "mid_fresh");

`ifdef PROG_LOADER_CHECKSUM_EN
      img.delete();
      img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
      run(1, "chk_ok");
      chk("chk_ok_done_fixed", done, 1);
      img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      run(0, "chk_bad");
      chk("chk_bad_err_fixed", error, 1);
      for (int k = 0; k < 4; k++) begin
         chk_flip = k % 2;
         mk(32'($urandom_range(4, 1)));
         run(-1, $sformatf("chk_rnd%0d", k));
      end
      chk_flip = 0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
